// File: rtl/cmos_pkg.sv
// cmos_pkg: shared defaults, limits and byte-order helper for the CMOS capture path
package cmos_pkg;
  localparam int DEF_IN_W = 8;
  localparam int DEF_CNT_W = 12;
  localparam int MAX_BYTES_PER_PIX = 4;
  function automatic int word_lsb(input int idx, input int bpp, input int in_w, input int msb_first);
    return (msb_first != 0 ? bpp - 1 - idx : idx) * in_w;
  endfunction
endpackage

// File: rtl/cmos_pixel_pack.sv
// cmos_pixel_pack: gathers BYTES_PER_PIX sensor words into one pixel and flags partial pixels at line end
module cmos_pixel_pack
  import cmos_pkg::*;
#(
  parameter int IN_W = DEF_IN_W,
  parameter int BYTES_PER_PIX = 2,
  parameter int MSB_FIRST = 1,
  parameter int OUT_W = IN_W * BYTES_PER_PIX
) (
  input  logic cam_pclk,
  input  logic rst_n,
  input  logic href,
  input  logic href_d0,
  input  logic [IN_W-1:0] data,
  output logic pix_done,
  output logic [OUT_W-1:0] pix_data,
  output logic line_err
);
  localparam int IDX_W = $clog2(MAX_BYTES_PER_PIX);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BYTES_PER_PIX - 1);
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic line_err_q, line_err_d;
  always_comb begin
    pix_data = acc_q;
    pix_data[word_lsb(int'(idx_q), BYTES_PER_PIX, IN_W, MSB_FIRST) +: IN_W] = data;
    pix_done = href && idx_q == IDX_LAST;
    idx_d = (href && idx_q != IDX_LAST) ? idx_q + IDX_W'(1) : '0;
    acc_d = href ? pix_data : acc_q;
    line_err_d = !href && href_d0 && idx_q != '0;
  end
  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      acc_q <= '0;
      line_err_q <= 1'b0;
    end else begin
      idx_q <= idx_d;
      acc_q <= acc_d;
      line_err_q <= line_err_d;
    end
  end
  assign line_err = line_err_q;
endmodule

// File: rtl/cmos_capture_window.sv
// cmos_capture_window: CMOS capture with start-up frame discard, pixel packing and a per-frame crop window
module cmos_capture_window
  import cmos_pkg::*;
#(
  parameter int IN_W = DEF_IN_W,
  parameter int BYTES_PER_PIX = 2,
  parameter int OUT_W = IN_W * BYTES_PER_PIX,
  parameter int WAIT_FRAME = 10,
  parameter int CNT_W = DEF_CNT_W,
  parameter int MSB_FIRST = 1
) (
  input  logic cam_pclk,
  input  logic rst_n,
  input  logic cam_vsync,
  input  logic cam_href,
  input  logic [IN_W-1:0] cam_data,
  input  logic [CNT_W-1:0] win_x_start,
  input  logic [CNT_W-1:0] win_x_end,
  input  logic [CNT_W-1:0] win_y_start,
  input  logic [CNT_W-1:0] win_y_end,
  output logic cmos_frame_vsync,
  output logic cmos_frame_href,
  output logic cmos_frame_valid,
  output logic [OUT_W-1:0] cmos_frame_data,
  output logic frame_ready,
  output logic [15:0] frame_cnt,
  output logic line_err
);
  localparam logic [7:0] WAIT_MAX = 8'(WAIT_FRAME);
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_FRAME - 1);
  logic vsync_d0_q, vsync_d0_d, vsync_d1_q, vsync_d1_d;
  logic href_d0_q, href_d0_d, href_d1_q, href_d1_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic ready_q, ready_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0] xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
  logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
  logic valid_q, valid_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic pix_done, pos_vsync, href_fall, in_win;
  logic [OUT_W-1:0] pix_data;
  cmos_pixel_pack #(
    .IN_W(IN_W),
    .BYTES_PER_PIX(BYTES_PER_PIX),
    .MSB_FIRST(MSB_FIRST),
    .OUT_W(OUT_W)
  ) u_pack (
    .cam_pclk(cam_pclk),
    .rst_n(rst_n),
    .href(cam_href),
    .href_d0(href_d0_q),
    .data(cam_data),
    .pix_done(pix_done),
    .pix_data(pix_data),
    .line_err(line_err)
  );
  assign pos_vsync = vsync_d0_q && !vsync_d1_q;
  assign href_fall = !href_d0_q && href_d1_q;
  assign in_win = x_q >= xs_q && x_q <= xe_q && y_q >= ys_q && y_q <= ye_q;
  always_comb begin
    vsync_d0_d = cam_vsync;
    vsync_d1_d = vsync_d0_q;
    href_d0_d = cam_href;
    href_d1_d = href_d0_q;
    wait_cnt_d = (pos_vsync && wait_cnt_q != WAIT_MAX) ? wait_cnt_q + 8'd1 : wait_cnt_q;
    ready_d = ready_q || (pos_vsync && wait_cnt_q == WAIT_LAST);
    frame_cnt_d = (pos_vsync && ready_q) ? frame_cnt_q + 16'd1 : frame_cnt_q;
    xs_d = pos_vsync ? win_x_start : xs_q;
    xe_d = pos_vsync ? win_x_end : xe_q;
    ys_d = pos_vsync ? win_y_start : ys_q;
    ye_d = pos_vsync ? win_y_end : ye_q;
    x_d = !cam_href ? '0 : (pix_done && x_q != '1) ? x_q + CNT_W'(1) : x_q;
    y_d = pos_vsync ? '0 : (href_fall && y_q != '1) ? y_q + CNT_W'(1) : y_q;
    valid_d = ready_q && pix_done && in_win;
    data_d = valid_d ? pix_data : data_q;
  end
  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d0_q <= 1'b0;
      vsync_d1_q <= 1'b0;
      href_d0_q <= 1'b0;
      href_d1_q <= 1'b0;
      wait_cnt_q <= '0;
      ready_q <= 1'b0;
      frame_cnt_q <= '0;
      xs_q <= '0;
      xe_q <= '0;
      ys_q <= '0;
      ye_q <= '0;
      x_q <= '0;
      y_q <= '0;
      valid_q <= 1'b0;
      data_q <= '0;
    end else begin
      vsync_d0_q <= vsync_d0_d;
      vsync_d1_q <= vsync_d1_d;
      href_d0_q <= href_d0_d;
      href_d1_q <= href_d1_d;
      wait_cnt_q <= wait_cnt_d;
      ready_q <= ready_d;
      frame_cnt_q <= frame_cnt_d;
      xs_q <= xs_d;
      xe_q <= xe_d;
      ys_q <= ys_d;
      ye_q <= ye_d;
      x_q <= x_d;
      y_q <= y_d;
      valid_q <= valid_d;
      data_q <= data_d;
    end
  end
  assign cmos_frame_vsync = ready_q && vsync_d1_q;
  assign cmos_frame_href = ready_q && href_d1_q;
  assign cmos_frame_valid = valid_q;
  assign cmos_frame_data = data_q;
  assign frame_ready = ready_q;
  assign frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_cmos_capture_window.sv
// tb_cmos_capture_window: randomized frame stimulus against a frame-level model with a scoreboarded pixel monitor
module tb_cmos_capture_window;
  localparam int WAIT = 2;
  typedef struct {
    logic [15:0] m;
    logic [15:0] l;
    int c;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic vsync = 1'b0;
  logic href = 1'b0;
  logic [7:0] data = 8'h00;
  logic [11:0] xs = '0, xe = '0, ys = '0, ye = '0;
  logic m_vs, m_hr, m_val, m_rdy, m_err, l_vs, l_hr, l_val, l_rdy, l_err;
  logic [15:0] m_data, m_fc, l_data, l_fc;
  int checks = 0, errors = 0, cyc = 0;
  int vs_cnt = 0, fc_exp = 0, line_y = 0, err_exp = 0, err_seen = 0, err_seen_l = 0;
  int sxs = 0, sxe = 0, sys = 0, sye = 0;
  exp_t exp_q[$];
  exp_t e;
  cmos_capture_window #(.IN_W(8), .BYTES_PER_PIX(2), .WAIT_FRAME(WAIT), .CNT_W(12), .MSB_FIRST(1)) dut (
    .cam_pclk(clk), .rst_n(rst_n), .cam_vsync(vsync), .cam_href(href), .cam_data(data),
    .win_x_start(xs), .win_x_end(xe), .win_y_start(ys), .win_y_end(ye),
    .cmos_frame_vsync(m_vs), .cmos_frame_href(m_hr), .cmos_frame_valid(m_val),
    .cmos_frame_data(m_data), .frame_ready(m_rdy), .frame_cnt(m_fc), .line_err(m_err)
  );
  cmos_capture_window #(.IN_W(8), .BYTES_PER_PIX(2), .WAIT_FRAME(WAIT), .CNT_W(12), .MSB_FIRST(0)) dut_lsb (
    .cam_pclk(clk), .rst_n(rst_n), .cam_vsync(vsync), .cam_href(href), .cam_data(data),
    .win_x_start(xs), .win_x_end(xe), .win_y_start(ys), .win_y_end(ye),
    .cmos_frame_vsync(l_vs), .cmos_frame_href(l_hr), .cmos_frame_valid(l_val),
    .cmos_frame_data(l_data), .frame_ready(l_rdy), .frame_cnt(l_fc), .line_err(l_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_err) err_seen++;
      if (l_err) err_seen_l++;
      if (m_val || l_val) begin
        chk("valid_pair", {m_val, l_val}, 2'b11);
        chk("valid_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("pixel_msb_first", m_data, e.m);
          chk("pixel_lsb_first", l_data, e.l);
          chk("valid_cycle", cyc, e.c);
        end
      end
    end
  end
  task automatic set_win(input int a, input int b, input int c, input int d);
    xs = 12'(a);
    xe = 12'(b);
    ys = 12'(c);
    ye = 12'(d);
  endtask
  task automatic vsync_pulse();
    @(negedge clk);
    vsync = 1'b1;
    vs_cnt++;
    if (vs_cnt > WAIT) fc_exp = (fc_exp + 1) & 16'hFFFF;
    sxs = int'(xs);
    sxe = int'(xe);
    sys = int'(ys);
    sye = int'(ye);
    line_y = 0;
    repeat (3) @(negedge clk);
    chk("frame_ready", m_rdy, vs_cnt >= WAIT);
    chk("frame_ready_lsb", l_rdy, vs_cnt >= WAIT);
    chk("frame_cnt", m_fc, 16'(fc_exp));
    chk("frame_cnt_lsb", l_fc, 16'(fc_exp));
    chk("frame_vsync", {m_vs, l_vs}, {2{vs_cnt >= WAIT}});
    vsync = 1'b0;
    repeat (3) @(negedge clk);
  endtask
  task automatic do_line(input int nb, input bit fixed);
    logic [7:0] b0, b;
    int x;
    bit rdy;
    x = 0;
    b0 = 8'h00;
    rdy = vs_cnt >= WAIT;
    for (int i = 0; i < nb; i++) begin
      @(negedge clk);
      if (i == 2) chk("frame_href", {m_hr, l_hr}, {2{rdy}});
      b = fixed ? (i[0] ? 8'h3C : 8'hA5) : 8'($urandom);
      href = 1'b1;
      data = b;
      if (i % 2 == 0) b0 = b;
      else begin
        if (rdy && x >= sxs && x <= sxe && line_y >= sys && line_y <= sye)
          exp_q.push_back('{m: {b0, b}, l: {b, b0}, c: cyc + 1});
        x++;
      end
    end
    @(negedge clk);
    href = 1'b0;
    data = 8'($urandom);
    if (nb % 2 != 0) err_exp++;
    repeat (4) @(negedge clk);
    chk("line_err_count", err_seen, err_exp);
    chk("line_err_count_lsb", err_seen_l, err_exp);
    line_y++;
  endtask
  task automatic do_frame(input int nl, input int nb, input bit fixed, input int mid);
    vsync_pulse();
    for (int l = 0; l < nl; l++) begin
      if (l == mid) set_win($urandom_range(0, 6), $urandom_range(0, 9), $urandom_range(0, 3), $urandom_range(0, 5));
      do_line(nb, fixed);
    end
    repeat (5) @(negedge clk);
  endtask
  task automatic rand_frame();
    set_win($urandom_range(0, 6), $urandom_range(0, 9), $urandom_range(0, 3), $urandom_range(0, 5));
    do_frame($urandom_range(2, 5), $urandom_range(3, 20), 1'b0, $urandom_range(0, 1) != 0 ? 1 : -1);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outputs", {m_vs, m_hr, m_val, m_rdy, m_err, m_fc, m_data}, '0);
    chk("reset_outputs_lsb", {l_vs, l_hr, l_val, l_rdy, l_err, l_fc, l_data}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    set_win(0, 7, 0, 3);
    repeat (3) do_frame(4, 16, 1'b0, -1);
    do_frame(2, 4, 1'b1, -1);
    set_win(2, 5, 1, 2);
    do_frame(4, 16, 1'b0, -1);
    do_frame(4, 16, 1'b0, 2);
    do_frame(4, 16, 1'b0, -1);
    set_win(0, 7, 0, 3);
    do_frame(3, 7, 1'b0, -1);
    set_win(5, 2, 0, 3);
    do_frame(2, 16, 1'b0, -1);
    repeat (10) rand_frame();
    set_win(5, 1, 0, 3);
    vsync_pulse();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      href = 1'b1;
      data = 8'($urandom);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midline_reset", {m_vs, m_hr, m_val, m_rdy, m_err, m_fc, m_data}, '0);
    chk("midline_reset_lsb", {l_vs, l_hr, l_val, l_rdy, l_err, l_fc, l_data}, '0);
    exp_q.delete();
    vs_cnt = 0;
    fc_exp = 0;
    href = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    set_win(0, 7, 0, 3);
    do_frame(2, 16, 1'b0, -1);
    do_frame(2, 16, 1'b0, -1);
    repeat (3) rand_frame();
    repeat (10) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end
endmodule
